mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter_pkg.sv | 16 +
 rtl/mux_rr_arbiter_if.sv | 32 +++
 rtl/mux_rr_arbiter_rr_pick.sv | 28 ++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, FSM state type and grant helper for the round-robin select arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = $clog2(N_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle for mux_rr_arbiter; the lock vector exists only when ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] data;
  logic             out_ready;
  logic             out_valid;
  logic             out_data;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
`ifdef ARB_LOCK_EN
  logic [N_REQ-1:0] lock;
`endif

  modport master (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req, data, out_ready,
    output out_valid, out_data, sel, gnt
  );

  modport slave (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req, data, out_ready,
    input  out_valid, out_data, sel, gnt
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Doubling the vector turns the rotate-right into a plain shift.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    any = |req;
    idx = off + ptr;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 16:1 mux select, with valid/ready output handshake.
// Optional grant locking is compiled in with ARB_LOCK_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.master  bus
);

  state_t           state, next_state;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic             data_q, data_n;
  logic [SEL_W-1:0] pick_ptr, pick_idx;
  logic             pick_any;
  logic             accept;
  logic             hold;

  assign accept = (state == GRANT) && bus.out_ready;

`ifdef ARB_LOCK_EN
  assign hold = accept && bus.lock[sel_q] && bus.req[sel_q];
`else
  assign hold = 1'b0;
`endif

  // On accept the search already starts past the outgoing grant, so back-to-back grants need no bubble.
  assign pick_ptr = accept ? sel_q + SEL_W'(1) : ptr;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      sel_q  <= '0;
      gnt_q  <= '0;
      data_q <= 1'b0;
    end else begin
      state  <= next_state;
      ptr    <= ptr_n;
      sel_q  <= sel_n;
      gnt_q  <= gnt_n;
      data_q <= data_n;
    end
  end

  always_comb begin
    next_state = state;
    ptr_n      = ptr;
    sel_n      = sel_q;
    gnt_n      = gnt_q;
    data_n     = data_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          next_state = GRANT;
          sel_n      = pick_idx;
          gnt_n      = onehot(pick_idx);
          data_n     = bus.data[pick_idx];
        end
      end
      GRANT: begin
        if (accept) begin
          if (hold) begin
            data_n = bus.data[sel_q];
          end else begin
            ptr_n = pick_ptr;
            if (pick_any) begin
              sel_n  = pick_idx;
              gnt_n  = onehot(pick_idx);
              data_n = bus.data[pick_idx];
            end else begin
              next_state = IDLE;
              gnt_n      = '0;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.out_valid = (state == GRANT);
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a queue-based reference model predicts every cycle's outputs.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  typedef struct packed {
    logic        v;
    logic [3:0]  s;
    logic [15:0] g;
    logic        d;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t expq[$];
  int   m_ptr;
  int   m_gr;
  int   m_sel;
  logic m_data;
  logic m_hold;
  exp_t e;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic [15:0] d, input logic rdy, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.req       = r;
      bus.data      = d;
      bus.out_ready = rdy;
    end
  endtask

  // Reference model: pending grant index (or -1), pointer, and search from ptr upwards mod 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  = 0;
      m_gr   = -1;
      m_sel  = 0;
      m_data = 1'b0;
      expq.delete();
    end else begin
      if (m_gr >= 0 && bus.out_ready) begin
        m_hold = 1'b0;
`ifdef ARB_LOCK_EN
        if (bus.lock[m_gr] && bus.req[m_gr]) begin
          m_hold = 1'b1;
          m_data = bus.data[m_gr];
        end
`endif
        if (!m_hold) begin
          m_ptr = (m_gr + 1) % 16;
          m_gr  = -1;
        end
      end
      if (m_gr < 0) begin
        for (int k = 0; k < 16; k++) begin
          if (m_gr < 0 && bus.req[(m_ptr + k) % 16]) begin
            m_gr   = (m_ptr + k) % 16;
            m_sel  = m_gr;
            m_data = bus.data[m_gr];
          end
        end
      end
      e.v = (m_gr >= 0);
      e.s = 4'(m_sel);
      e.g = (m_gr >= 0) ? (16'h1 << m_gr) : 16'h0;
      e.d = m_data;
      expq.push_back(e);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (expq.size() == 0) begin
        checkOutput("queue_empty", 32'd0, 32'd1);
      end else begin
        exp_t x;
        x = expq.pop_front();
        checkOutput("out_valid", 32'(bus.out_valid), 32'(x.v));
        checkOutput("sel",       32'(bus.sel),       32'(x.s));
        checkOutput("gnt",       32'(bus.gnt),       32'(x.g));
        checkOutput("out_data",  32'(bus.out_data),  32'(x.d));
      end
    end
  end

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b1;
    bus.req       = '0;
    bus.data      = '0;
    bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock      = '0;
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sel",   32'(bus.sel),       32'd0);
    checkOutput("rst_gnt",   32'(bus.gnt),       32'd0);
    checkOutput("rst_data",  32'(bus.out_data),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic latency");
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 3);

    $display("[TB] wrap and skip");
    applyStimulus(16'h4000, 16'h0000, 1'b1, 1);
    applyStimulus(16'h4003, 16'h4002, 1'b1, 4);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 2);

    $display("[TB] rotation with all requesting");
    applyStimulus(16'hFFFF, 16'hA5C3, 1'b1, 20);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 2);

    $display("[TB] backpressure freeze");
    applyStimulus(16'h0008, 16'h0008, 1'b0, 1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(16'h0000, (c % 2 == 0) ? 16'h0000 : 16'h0008, 1'b0, 1);
    end
    applyStimulus(16'h0000, 16'h0000, 1'b1, 2);

    $display("[TB] reset mid-transfer");
    applyStimulus(16'h0010, 16'h0010, 1'b0, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_gnt",   32'(bus.gnt),       32'd0);
    checkOutput("abort_sel",   32'(bus.sel),       32'd0);
    checkOutput("abort_data",  32'(bus.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h0001, 16'h0000, 1'b0, 2);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 2);

`ifdef ARB_LOCK_EN
    $display("[TB] locked grant");
    bus.lock = 16'h0001;
    applyStimulus(16'h0021, 16'h0021, 1'b1, 4);
    bus.lock = 16'h0000;
    applyStimulus(16'h0021, 16'h0020, 1'b1, 4);
`endif

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      logic [15:0] r;
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'h1 << $urandom_range(0, 15);
        2:       r = 16'($urandom);
        default: r = 16'hFFFF;
      endcase
`ifdef ARB_LOCK_EN
      bus.lock = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
`endif
      applyStimulus(r, 16'($urandom), ($urandom_range(0, 9) < 6), 1);
    end

    applyStimulus(16'h0000, 16'h0000, 1'b1, 4);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
